sdf_stage_ctrl: RTL and testbench

Sequencing controller for one radix-2 DIF single-path delay-feedback (SDF) FFT stage. It drives the stage's delay line, butterfly/bypass muxes and twiddle ROM address from a valid/ready sample stream. It also drains the delay line after each frame so every input frame yields the same number of output samples. One instance sits beside each stage's BFU and delay line; the stage delay length is set by parameter.

---
 rtl/sdf_stage_ctrl.sv | 152 +++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 DIF single-path delay-feedback FFT stage.
// Tracks the position of each accepted sample inside its 2D block, drives the
// delay-line / butterfly / output muxes and the twiddle ROM address, and drains
// the delay line with D zero-input shifts after every frame.
module sdf_stage_ctrl #(
    parameter int FFT_N       = 16,
    parameter int STAGE_DELAY = 8,
    parameter int CNT_W       = $clog2(2 * STAGE_DELAY),
    parameter int TW_W        = (FFT_N > 2) ? $clog2(FFT_N / 2) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    output logic            shift_en,
    output logic            bfu_sel,
    output logic            out_sel,
    output logic            zero_in,
    output logic [TW_W-1:0] tw_addr,
    output logic            out_valid,
    output logic            out_last,
    output logic            frame_err
);

    // Twiddle stride: a stage with delay D walks the ROM in steps of N/(2D).
    localparam int TW_SHIFT = $clog2(FFT_N / (2 * STAGE_DELAY));

    localparam logic [CNT_W-1:0] D_CNT      = CNT_W'(STAGE_DELAY);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(2 * STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(STAGE_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             primed;
    logic             primed_nxt;
    logic             err_flag;
    logic             err_nxt;
    logic             accept;
    logic [CNT_W-1:0] blk_off;

    // A sample is taken whenever we are out of reset, not draining, and upstream offers one.
    assign accept  = reset_n & in_valid & (state != FLUSH);

    // Offset of the current sample inside the butterfly half of the block.
    assign blk_off = cnt - D_CNT;

    // State, position counter, primed flag and pending length-error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            primed   <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            primed   <= primed_nxt;
            err_flag <= err_nxt;
        end
    end

    // Next-state logic: count accepted samples modulo 2D, then count D drain cycles.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        primed_nxt = primed;
        err_nxt    = err_flag;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    if (in_last) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = '0;
                        err_nxt   = (cnt != LAST_CNT);
                    end else begin
                        state_nxt = RUN;
                        if (cnt == LAST_CNT) begin
                            cnt_nxt    = '0;
                            primed_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    primed_nxt = 1'b0;
                    err_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                primed_nxt = 1'b0;
                err_nxt    = 1'b0;
            end
        endcase
    end

    // Output decode; everything is held low while reset_n is asserted.
    always_comb begin
        in_ready  = 1'b0;
        shift_en  = 1'b0;
        bfu_sel   = 1'b0;
        out_sel   = 1'b0;
        zero_in   = 1'b0;
        tw_addr   = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        frame_err = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE, RUN: begin
                    in_ready  = 1'b1;
                    shift_en  = accept;
                    bfu_sel   = (cnt >= D_CNT);
                    out_sel   = ~(cnt >= D_CNT);
                    if (cnt >= D_CNT) begin
                        tw_addr = TW_W'(TW_W'(blk_off) << TW_SHIFT);
                    end
                    out_valid = accept & ((cnt >= D_CNT) | primed);
                end
                FLUSH: begin
                    shift_en  = 1'b1;
                    zero_in   = 1'b1;
                    out_sel   = 1'b1;
                    out_valid = 1'b1;
                    out_last  = (cnt == FLUSH_LAST);
                    frame_err = err_flag & (cnt == '0);
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl at FFT_N=16, D=4.
// A frame-level reference model (sample index within the frame, flush index)
// predicts every output each cycle; per-frame totals are checked against the
// counts a well-formed or short frame must produce.
module tb_sdf_stage_ctrl;

    localparam int N    = 16;
    localparam int D    = 4;
    localparam int TW_W = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_last = 1'b0;
    logic            shift_en;
    logic            bfu_sel;
    logic            out_sel;
    logic            zero_in;
    logic [TW_W-1:0] tw_addr;
    logic            out_valid;
    logic            out_last;
    logic            frame_err;

    int tests = 0;
    int fails = 0;

    // Reference model: samples taken in the current frame, drain progress, length error.
    bit m_flush   = 1'b0;
    int m_k       = 0;
    int m_f       = 0;
    bit m_len_err = 1'b0;

    sdf_stage_ctrl #(.FFT_N(N), .STAGE_DELAY(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .shift_en  (shift_en),
        .bfu_sel   (bfu_sel),
        .out_sel   (out_sel),
        .zero_in   (zero_in),
        .tw_addr   (tw_addr),
        .out_valid (out_valid),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Drive one clock cycle; returns model-predicted and observed output vectors.
    // Vector: {in_ready, shift_en, bfu_sel, out_sel, zero_in, out_valid, out_last, frame_err, tw_addr}
    task automatic cycle(input logic rst_n, input logic v, input logic l,
                         output logic [10:0] ev, output logic [10:0] av);
        int   p;
        logic bfu;
        @(negedge clk);
        reset_n  = rst_n;
        in_valid = v;
        in_last  = l;
        #1;
        av = {in_ready, shift_en, bfu_sel, out_sel, zero_in, out_valid, out_last, frame_err, tw_addr};
        if (!rst_n) begin
            ev = '0;
        end else if (!m_flush) begin
            p   = m_k % (2 * D);
            bfu = (p >= D);
            ev  = {1'b1, v, bfu, !bfu, 1'b0, v && (m_k >= D), 1'b0, 1'b0,
                   bfu ? TW_W'((p - D) * (N / (2 * D))) : TW_W'(0)};
        end else begin
            ev = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, (m_f == D - 1), (m_f == 0) && m_len_err, TW_W'(0)};
        end
        @(posedge clk);
        if (!rst_n) begin
            m_flush = 0; m_k = 0; m_f = 0; m_len_err = 0;
        end else if (!m_flush) begin
            if (v) begin
                m_k++;
                if (l) begin
                    m_flush   = 1;
                    m_f       = 0;
                    m_len_err = (m_k % (2 * D)) != 0;
                    m_k       = 0;
                end
            end
        end else begin
            m_f++;
            if (m_f == D) m_flush = 0;
        end
    endtask

    // Run one frame of len samples (mode 0 continuous, 1 toggled valid, 2 random valid),
    // then nflush drain cycles, checking every cycle and tallying key outputs.
    task automatic run_frame(input string name, input int len, input int mode,
                             input logic vflush, input int nflush,
                             output int nov, output int nlast, output int nerr, output int nrdylow);
        int          acc;
        int          cyc;
        logic        v;
        logic [10:0] ev;
        logic [10:0] av;
        acc = 0; cyc = 0; nov = 0; nlast = 0; nerr = 0; nrdylow = 0;
        while (acc < len && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            cycle(1'b1, v, (acc == len - 1), ev, av);
            tests++;
            if (av !== ev) begin
                fails++;
                $display("[TB] FAIL %s sample cyc %0d: got %b expected %b", name, cyc, av, ev);
            end
            if (v) acc++;
            nov += int'(av[5]); nlast += int'(av[4]); nerr += int'(av[3]); nrdylow += int'(!av[10]);
            cyc++;
        end
        tests++;
        if (acc < len) begin
            fails++;
            $display("[TB] FAIL %s timeout: got %0d accepts expected %0d", name, acc, len);
        end
        for (int i = 0; i < nflush; i++) begin
            cycle(1'b1, vflush, vflush, ev, av);
            tests++;
            if (av !== ev) begin
                fails++;
                $display("[TB] FAIL %s flush cyc %0d: got %b expected %b", name, i, av, ev);
            end
            nov += int'(av[5]); nlast += int'(av[4]); nerr += int'(av[3]); nrdylow += int'(!av[10]);
        end
    endtask

    task automatic test_reset();
        logic [10:0] ev;
        logic [10:0] av;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, ev, av);
            tests++;
            if (av !== 11'd0) begin
                fails++;
                $display("[TB] FAIL reset_hold cyc %0d: got %b expected %b", i, av, 11'd0);
            end
        end
        cycle(1'b1, 1'b0, 1'b0, ev, av);
        tests++;
        if (av !== 11'b100_1000_0000) begin
            fails++;
            $display("[TB] FAIL reset_release: got %b expected %b", av, 11'b100_1000_0000);
        end
    endtask

    task automatic test_continuous();
        int nov, nlast, nerr, nrdy;
        run_frame("continuous", N, 0, 1'b0, D, nov, nlast, nerr, nrdy);
        tests += 3;
        if (nov !== N)   begin fails++; $display("[TB] FAIL continuous out_valid count: got %0d expected %0d", nov, N); end
        if (nlast !== 1) begin fails++; $display("[TB] FAIL continuous out_last count: got %0d expected 1", nlast); end
        if (nerr !== 0)  begin fails++; $display("[TB] FAIL continuous frame_err count: got %0d expected 0", nerr); end
    endtask

    task automatic test_stall_toggle();
        int nov, nlast, nerr, nrdy;
        run_frame("toggle", N, 1, 1'b0, D, nov, nlast, nerr, nrdy);
        tests += 2;
        if (nov !== N)   begin fails++; $display("[TB] FAIL toggle out_valid count: got %0d expected %0d", nov, N); end
        if (nlast !== 1) begin fails++; $display("[TB] FAIL toggle out_last count: got %0d expected 1", nlast); end
    endtask

    task automatic test_short_frame();
        int nov, nlast, nerr, nrdy;
        run_frame("short", 10, 0, 1'b0, D, nov, nlast, nerr, nrdy);
        tests += 3;
        if (nerr !== 1)  begin fails++; $display("[TB] FAIL short frame_err count: got %0d expected 1", nerr); end
        if (nlast !== 1) begin fails++; $display("[TB] FAIL short out_last count: got %0d expected 1", nlast); end
        if (nov !== 10)  begin fails++; $display("[TB] FAIL short out_valid count: got %0d expected 10", nov); end
    endtask

    task automatic test_back_to_back();
        int nov, nlast, nerr, nrdy;
        run_frame("b2b_first", N, 0, 1'b1, D, nov, nlast, nerr, nrdy);
        tests++;
        if (nrdy !== D) begin fails++; $display("[TB] FAIL b2b in_ready low cycles: got %0d expected %0d", nrdy, D); end
        run_frame("b2b_second", N, 0, 1'b1, D, nov, nlast, nerr, nrdy);
        tests++;
        if (nov !== N) begin fails++; $display("[TB] FAIL b2b second out_valid count: got %0d expected %0d", nov, N); end
    endtask

    task automatic test_reset_mid_flush();
        int          nov, nlast, nerr, nrdy;
        logic [10:0] ev;
        logic [10:0] av;
        run_frame("rst_flush", N, 0, 1'b0, 1, nov, nlast, nerr, nrdy);
        cycle(1'b0, 1'b0, 1'b0, ev, av);
        tests++;
        if (av !== 11'd0) begin fails++; $display("[TB] FAIL rst_flush during reset: got %b expected %b", av, 11'd0); end
        tests++;
        if (nlast !== 0) begin fails++; $display("[TB] FAIL rst_flush out_last count: got %0d expected 0", nlast); end
        run_frame("after_rst", N, 0, 1'b0, D, nov, nlast, nerr, nrdy);
        tests += 2;
        if (nov !== N)   begin fails++; $display("[TB] FAIL after_rst out_valid count: got %0d expected %0d", nov, N); end
        if (nlast !== 1) begin fails++; $display("[TB] FAIL after_rst out_last count: got %0d expected 1", nlast); end
    endtask

    task automatic test_random();
        int nov, nlast, nerr, nrdy, len, exp_ov;
        for (int f = 0; f < 8; f++) begin
            len    = $urandom_range(1, 3 * N / 2);
            exp_ov = ((len > D) ? len - D : 0) + D;
            run_frame("random", len, 2, 1'($urandom_range(0, 1)), D, nov, nlast, nerr, nrdy);
            tests += 3;
            if (nov !== exp_ov) begin fails++; $display("[TB] FAIL random len %0d out_valid count: got %0d expected %0d", len, nov, exp_ov); end
            if (nlast !== 1)    begin fails++; $display("[TB] FAIL random len %0d out_last count: got %0d expected 1", len, nlast); end
            if (nerr !== int'((len % (2 * D)) != 0)) begin
                fails++;
                $display("[TB] FAIL random len %0d frame_err count: got %0d expected %0d", len, nerr, int'((len % (2 * D)) != 0));
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_continuous();
        test_stall_toggle();
        test_short_frame();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
